// File: rtl/adam_sd_pkg.sv
// Shared types and constants for the Adam SD block transfer engine.
package adam_sd_pkg;

    localparam int SD_SECT_BYTES = 512;
    localparam int SD_ADDR_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_NEXT,
        ST_FINISH,
        ST_ERR
    } xfer_state_t;

endpackage

// File: rtl/adam_sd_block_xfer_if.sv
// Bundle of the request, HPS SD and buffer port-B signals around adam_sd_block_xfer.
// The transfer engine uses the slave view; the surrounding system uses the master view.
interface adam_sd_block_xfer_if #(
    parameter int ADDR_W = 10
);

    // drive emulation side
    logic        req_rd;
    logic        req_wr;
    logic [31:0] blk_lba;
    logic        busy;
    logic        done;
    logic        error;

    // HPS SD side
    logic [31:0]                        sd_lba;
    logic                               sd_rd;
    logic                               sd_wr;
    logic                               sd_ack;
    logic [adam_sd_pkg::SD_ADDR_W-1:0]  sd_buff_addr;
    logic [7:0]                         sd_buff_dout;
    logic                               sd_buff_wr;
    logic [7:0]                         sd_buff_din;

    // buffer RAM port B
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [7:0]        ram_data;
    logic [7:0]        ram_q;

    modport master (
        output req_rd, req_wr, blk_lba,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output ram_q,
        input  busy, done, error,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  ram_addr, ram_wren, ram_data
    );

    modport slave (
        input  req_rd, req_wr, blk_lba,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  ram_q,
        output busy, done, error,
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        output ram_addr, ram_wren, ram_data
    );

endinterface

// File: rtl/adam_sd_block_xfer.sv
// Moves one Adam block (SECT_PER_BLK SD sectors) between the HPS SD interface and
// port B of the disk-block buffer RAM, in either direction.
module adam_sd_block_xfer
    import adam_sd_pkg::*;
#(
    parameter int          ADDR_W       = 10,
    parameter int          SECT_PER_BLK = 2,
    parameter logic [23:0] TIMEOUT      = 24'hFFFFFF
) (
    input  logic clk_sys,
    input  logic reset,
    adam_sd_block_xfer_if.slave bus
);

    localparam int SIDX_W   = (ADDR_W > SD_ADDR_W) ? ADDR_W - SD_ADDR_W : 1;
    localparam int LOG2_SPB = $clog2(SECT_PER_BLK);
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(SECT_PER_BLK - 1);

    xfer_state_t       state;
    xfer_state_t       state_nxt;
    logic              dir_wr;
    logic [31:0]       lba;
    logic [SIDX_W-1:0] sidx;
    logic [23:0]       tcnt;
    logic              error_r;
    logic              accept;
    logic              tcnt_last;

    assign accept    = (state == ST_IDLE) && (bus.req_rd || bus.req_wr);
    assign tcnt_last = (tcnt == TIMEOUT - 24'd1);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (bus.sd_ack)     state_nxt = ST_XFER;
                else if (tcnt_last) state_nxt = ST_ERR;
            end
            ST_XFER:   if (!bus.sd_ack) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = (sidx == SIDX_LAST) ? ST_FINISH : ST_ISSUE;
            ST_FINISH: state_nxt = ST_IDLE;
            ST_ERR:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, sector index, ack timeout and sticky error.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dir_wr  <= 1'b0;
            lba     <= '0;
            sidx    <= '0;
            tcnt    <= '0;
            error_r <= 1'b0;
        end else begin
            if (accept) begin
                dir_wr  <= !bus.req_rd;   // read wins a simultaneous request
                lba     <= bus.blk_lba;
                sidx    <= '0;
                error_r <= 1'b0;
            end
            if (state == ST_NEXT && sidx != SIDX_LAST) begin
                sidx <= sidx + 1'b1;
            end
            if (state == ST_ISSUE && !bus.sd_ack && tcnt_last) begin
                error_r <= 1'b1;
            end
            tcnt <= (state == ST_ISSUE) ? tcnt + 24'd1 : 24'd0;
        end
    end

    always_comb begin
        bus.busy     = (state == ST_ISSUE) || (state == ST_XFER) || (state == ST_NEXT);
        bus.done     = (state == ST_FINISH) || (state == ST_ERR);
        bus.sd_rd    = (state == ST_ISSUE) && !dir_wr;
        bus.sd_wr    = (state == ST_ISSUE) && dir_wr;
        bus.ram_addr = '0;
        // Address is presented from ISSUE so the first write-direction byte is prefetched.
        if (state == ST_ISSUE || state == ST_XFER) begin
            bus.ram_addr = ADDR_W'({sidx, bus.sd_buff_addr});
        end
        bus.ram_wren = (state == ST_XFER) && !dir_wr && bus.sd_buff_wr && bus.sd_ack;
    end

    // Sector number wraps modulo 2^32; data paths are pure pass-through.
    assign bus.sd_lba      = (lba << LOG2_SPB) + 32'(sidx);
    assign bus.error       = error_r;
    assign bus.ram_data    = bus.sd_buff_dout;
    assign bus.sd_buff_din = bus.ram_q;

endmodule
